// File: rtl/oup_phyreg_access_ctrl.sv
// oup_phyreg_access_ctrl: sequences single PHY register reads/writes onto the ULPI sync-mode SM,
// retrying transactions the PHY aborts and returning exactly one response per request.
// Ports:
//   ulpi_clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i : request from link controller
//   rsp_valid_o/rsp_rdata_o/rsp_error_o                          : one-cycle response
//   instruction_o/exec_o/phyreg_o/phyreg_addr_o                  : command to the SM
//   exec_done_i/exec_aborted_i/phyreg_i/phyreg_addr_i            : completion from the SM
module oup_phyreg_access_ctrl #(
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_GAP      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_error_o,
  output logic [7:0] instruction_o,
  output logic       exec_o,
  input  logic       exec_done_i,
  input  logic       exec_aborted_i,
  output logic [7:0] phyreg_o,
  output logic [7:0] phyreg_addr_o,
  input  logic [7:0] phyreg_i,
  input  logic [7:0] phyreg_addr_i
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = RETRY_GAP > 1 ? $clog2(RETRY_GAP) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BACKOFF, RESP} state_e;
  state_e state_q, state_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ext, busy, accept;
  // Addresses from 0x2F upward go through the extended-register instruction.
  assign ext = addr_q >= 8'h2F;
  assign busy = state_q != IDLE;
  // Gated by reset so ready stays low while reset is held.
  assign req_ready_o = rst_i && state_q == IDLE;
  assign accept = req_valid_i && req_ready_o;
  assign instruction_o = busy ? {wr_q ? 2'b10 : 2'b11, ext ? 6'h2F : addr_q[5:0]} : 8'h00;
  assign phyreg_addr_o = busy ? addr_q : 8'h00;
  assign phyreg_o = busy && wr_q ? wdata_q : 8'h00;
  assign exec_o = state_q == ISSUE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_error_o = rsp_valid_o && err_q;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 8'h00;
  always_ff @(posedge ulpi_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      retry_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: if (accept) begin
        wr_d    = req_write_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        retry_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // Abort is checked first: a simultaneous done carries unreliable data.
        if (exec_aborted_i) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            err_d   = 1'b1;
            rdata_d = 8'h00;
            state_d = RESP;
          end else begin
            retry_d = retry_q + 1'b1;
            gap_d   = '0;
            state_d = RETRY_GAP == 0 ? ISSUE : BACKOFF;
          end
        end else if (exec_done_i) begin
          err_d   = !wr_q && ext && phyreg_addr_i != addr_q;
          rdata_d = wr_q || err_d ? 8'h00 : phyreg_i;
          state_d = RESP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rdata_d = 8'h00;
          state_d = RESP;
        end
      end
      BACKOFF: begin
        gap_d   = gap_q + 1'b1;
        state_d = gap_q == GW'(RETRY_GAP - 1) ? ISSUE : BACKOFF;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_oup_phyreg_access_ctrl.sv
// tb_oup_phyreg_access_ctrl: scoreboard bench for the PHY register access sequencer
module tb_oup_phyreg_access_ctrl;
  localparam int MAX_RETRY = 3, RETRY_GAP = 2, TIMEOUT_CYCLES = 255;
  logic clk = 1'b0, rst_i = 1'b0;
  logic req_valid_i = 1'b0, req_write_i = 1'b0, exec_done_i = 1'b0, exec_aborted_i = 1'b0;
  logic [7:0] req_addr_i = 8'h00, req_wdata_i = 8'h00, phyreg_i = 8'h00, phyreg_addr_i = 8'h00;
  logic req_ready_o, rsp_valid_o, rsp_error_o, exec_o;
  logic [7:0] rsp_rdata_o, instruction_o, phyreg_o, phyreg_addr_o;
  logic [8:0] sb[$];
  int n_chk = 0, n_err = 0, n_exec = 0, cyc = 0;
  oup_phyreg_access_ctrl #(.MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .ulpi_clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .instruction_o(instruction_o), .exec_o(exec_o), .exec_done_i(exec_done_i),
    .exec_aborted_i(exec_aborted_i), .phyreg_o(phyreg_o), .phyreg_addr_o(phyreg_addr_o),
    .phyreg_i(phyreg_i), .phyreg_addr_i(phyreg_addr_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (exec_o) n_exec <= n_exec + 1;
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) if (rsp_valid_o) begin
    if (sb.size() == 0) chk("rsp_unexpected", rsp_valid_o, 1'b0);
    else chk("rsp", {rsp_error_o, rsp_rdata_o}, sb.pop_front());
  end
  task automatic send(input logic wr, input logic [7:0] addr, input logic [7:0] wdata, input logic err, input logic [7:0] rdata);
    chk("ready_before_req", req_ready_o, 1'b1);
    sb.push_back({err, rdata});
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wdata;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask
  task automatic wait_exec(output int e);
    for (int i = 0; i < 60 && !exec_o; i++) @(negedge clk);
    chk("exec_seen", exec_o, 1'b1);
    e = cyc;
  endtask
  task automatic respond(input int k, input logic d, input logic a, input logic [7:0] data, input logic [7:0] echo);
    repeat (k) @(negedge clk);
    exec_done_i = d; exec_aborted_i = a; phyreg_i = data; phyreg_addr_i = echo;
    @(negedge clk);
    exec_done_i = 1'b0; exec_aborted_i = 1'b0;
  endtask
  task automatic simple(input logic wr, input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] instr,
                        input int k, input logic [7:0] data, input logic [7:0] echo, input logic err, input logic [7:0] rdata);
    int e, n0;
    n0 = n_exec;
    send(wr, addr, wdata, err, rdata);
    chk("exec_latency", exec_o, 1'b1);
    wait_exec(e);
    chk("instruction", instruction_o, instr);
    chk("phyreg_o", phyreg_o, wr ? wdata : 8'h00);
    chk("phyreg_addr_o", phyreg_addr_o, addr);
    respond(k, 1'b1, 1'b0, data, echo);
    chk("rsp_latency", rsp_valid_o, 1'b1);
    chk("exec_count", n_exec - n0, 1);
    @(negedge clk);
    chk("ready_after_rsp", req_ready_o, 1'b1);
  endtask
  initial begin
    int e1, e2, n0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o, instruction_o, exec_o, phyreg_o, phyreg_addr_o}, 0);
    rst_i = 1'b1;
    #1 chk("ready_after_release", req_ready_o, 1'b1);
    @(negedge clk);
    simple(1'b1, 8'h04, 8'h45, 8'h84, 3, 8'hEE, 8'h00, 1'b0, 8'h00);
    simple(1'b0, 8'h3A, 8'h00, 8'hEF, 2, 8'hA5, 8'h3A, 1'b0, 8'hA5);
    simple(1'b0, 8'h2E, 8'h00, 8'hEE, 1, 8'h12, 8'hFF, 1'b0, 8'h12);
    simple(1'b1, 8'h2F, 8'h9C, 8'hAF, 2, 8'h55, 8'h00, 1'b0, 8'h00);
    simple(1'b0, 8'h40, 8'h00, 8'hEF, 1, 8'h99, 8'h41, 1'b1, 8'h00);
    // two aborts then done
    n0 = n_exec;
    send(1'b0, 8'h0A, 8'h00, 1'b0, 8'h5C);
    wait_exec(e1);
    respond(1, 1'b0, 1'b1, 8'h00, 8'h00);
    wait_exec(e2);
    chk("retry_gap1", e2 - e1, 2 + RETRY_GAP);
    chk("retry_instr", instruction_o, 8'hCA);
    respond(1, 1'b0, 1'b1, 8'h00, 8'h00);
    wait_exec(e1);
    chk("retry_gap2", e1 - e2, 2 + RETRY_GAP);
    respond(2, 1'b1, 1'b0, 8'h5C, 8'h0A);
    chk("retry_rsp", rsp_valid_o, 1'b1);
    chk("retry_exec_count", n_exec - n0, 3);
    @(negedge clk);
    // every attempt aborted
    n0 = n_exec;
    send(1'b1, 8'h07, 8'h31, 1'b1, 8'h00);
    for (int i = 0; i <= MAX_RETRY; i++) begin
      wait_exec(e1);
      respond(1, 1'b0, 1'b1, 8'h00, 8'h00);
    end
    chk("exhaust_rsp", rsp_valid_o, 1'b1);
    chk("exhaust_exec_count", n_exec - n0, MAX_RETRY + 1);
    @(negedge clk);
    // done/aborted while idle are ignored
    n0 = n_exec;
    exec_done_i = 1'b1; exec_aborted_i = 1'b1;
    repeat (3) @(negedge clk);
    exec_done_i = 1'b0; exec_aborted_i = 1'b0;
    chk("idle_ignore_ready", req_ready_o, 1'b1);
    chk("idle_ignore_exec", n_exec - n0, 0);
    // timeout
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
    wait_exec(e1);
    for (int i = 0; i < 400 && !rsp_valid_o; i++) @(negedge clk);
    chk("timeout_rsp", rsp_valid_o, 1'b1);
    chk("timeout_cycles", cyc - e1, TIMEOUT_CYCLES + 1);
    @(negedge clk);
    chk("timeout_ready", req_ready_o, 1'b1);
    // reset in WAIT
    send(1'b0, 8'h16, 8'h00, 1'b0, 8'h00);
    wait_exec(e1);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1 chk("midreset_outputs", {req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o, instruction_o, exec_o, phyreg_o, phyreg_addr_o}, 0);
    sb.delete();
    n0 = n_exec;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1 chk("midreset_ready", req_ready_o, 1'b1);
    repeat (5) @(negedge clk);
    chk("midreset_no_exec", n_exec - n0, 0);
    // simultaneous done+aborted: the abort forces a retry
    send(1'b0, 8'h16, 8'h00, 1'b0, 8'h33);
    wait_exec(e1);
    respond(2, 1'b1, 1'b1, 8'h77, 8'h16);
    wait_exec(e2);
    chk("both_retry_gap", e2 - e1, 3 + RETRY_GAP);
    respond(1, 1'b1, 1'b0, 8'h33, 8'h16);
    chk("both_rsp", rsp_valid_o, 1'b1);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
